// File: rtl/ps2_pkg.sv
// Shared FSM state, PS/2 set-2 prefix/modifier codes and the scan-code to ASCII translator.
// Pure combinational helper; no latency or flow control lives here.
package ps2_pkg;

  typedef enum logic [1:0] {READY, DECODE, PUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [6:0] ascii;
  } xlat_t;

  localparam logic [7:0] CODE_BREAK   = 8'hF0;
  localparam logic [7:0] CODE_EXT     = 8'hE0;
  localparam logic [7:0] CODE_SHIFT_L = 8'h12;
  localparam logic [7:0] CODE_SHIFT_R = 8'h59;
  localparam logic [7:0] CODE_CTRL    = 8'h14;
  localparam logic [7:0] CODE_CAPS    = 8'h58;
  localparam logic [7:0] CODE_DEL     = 8'h71;

  function automatic xlat_t ps2_xlat(input logic [7:0] code, input logic shift,
                                     input logic caps, input logic ctrl, input logic e0);
    logic       v;
    logic [6:0] a;
    logic [6:0] letter;
    v = 1'b0;
    a = 7'h00;
    letter = 7'h00;
    if (e0) begin
      if (code == CODE_DEL) {v, a} = {1'b1, 7'h7F};
    end else begin
      case (code)
        8'h1C: letter = 7'h61;  8'h32: letter = 7'h62;  8'h21: letter = 7'h63;
        8'h23: letter = 7'h64;  8'h24: letter = 7'h65;  8'h2B: letter = 7'h66;
        8'h34: letter = 7'h67;  8'h33: letter = 7'h68;  8'h43: letter = 7'h69;
        8'h3B: letter = 7'h6A;  8'h42: letter = 7'h6B;  8'h4B: letter = 7'h6C;
        8'h3A: letter = 7'h6D;  8'h31: letter = 7'h6E;  8'h44: letter = 7'h6F;
        8'h4D: letter = 7'h70;  8'h15: letter = 7'h71;  8'h2D: letter = 7'h72;
        8'h1B: letter = 7'h73;  8'h2C: letter = 7'h74;  8'h3C: letter = 7'h75;
        8'h2A: letter = 7'h76;  8'h1D: letter = 7'h77;  8'h22: letter = 7'h78;
        8'h35: letter = 7'h79;  8'h1A: letter = 7'h7A;
        8'h16: {v, a} = {1'b1, shift ? 7'h21 : 7'h31};
        8'h1E: {v, a} = {1'b1, shift ? 7'h40 : 7'h32};
        8'h26: {v, a} = {1'b1, shift ? 7'h23 : 7'h33};
        8'h25: {v, a} = {1'b1, shift ? 7'h24 : 7'h34};
        8'h2E: {v, a} = {1'b1, shift ? 7'h25 : 7'h35};
        8'h36: {v, a} = {1'b1, shift ? 7'h5E : 7'h36};
        8'h3D: {v, a} = {1'b1, shift ? 7'h26 : 7'h37};
        8'h3E: {v, a} = {1'b1, shift ? 7'h2A : 7'h38};
        8'h46: {v, a} = {1'b1, shift ? 7'h28 : 7'h39};
        8'h45: {v, a} = {1'b1, shift ? 7'h29 : 7'h30};
        8'h0E: {v, a} = {1'b1, shift ? 7'h7E : 7'h60};
        8'h4E: {v, a} = {1'b1, shift ? 7'h5F : 7'h2D};
        8'h55: {v, a} = {1'b1, shift ? 7'h2B : 7'h3D};
        8'h54: {v, a} = {1'b1, shift ? 7'h7B : 7'h5B};
        8'h5B: {v, a} = {1'b1, shift ? 7'h7D : 7'h5D};
        8'h5D: {v, a} = {1'b1, shift ? 7'h7C : 7'h5C};
        8'h4C: {v, a} = {1'b1, shift ? 7'h3A : 7'h3B};
        8'h52: {v, a} = {1'b1, shift ? 7'h22 : 7'h27};
        8'h41: {v, a} = {1'b1, shift ? 7'h3C : 7'h2C};
        8'h49: {v, a} = {1'b1, shift ? 7'h3E : 7'h2E};
        8'h4A: {v, a} = {1'b1, shift ? 7'h3F : 7'h2F};
        8'h29: {v, a} = {1'b1, 7'h20};
        8'h66: {v, a} = {1'b1, 7'h08};
        8'h0D: {v, a} = {1'b1, 7'h09};
        8'h5A: {v, a} = {1'b1, 7'h0D};
        8'h76: {v, a} = {1'b1, 7'h1B};
        default: ;
      endcase
    end
    // Ctrl takes precedence over case so ctrl+letter always yields a control code.
    if (letter != 7'h00) begin
      v = 1'b1;
      if (ctrl)              a = letter - 7'h60;
      else if (shift ^ caps) a = letter - 7'h20;
      else                   a = letter;
    end
    return {v, a};
  endfunction

endpackage

// File: rtl/ascii_fifo.sv
// Registered-pointer queue, head shown combinationally (write visible next cycle).
// Full push without a same-cycle pop is dropped and flags a sticky overflow.
module ascii_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, do_push, do_pop;

  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // A fresh drop wins over a clear in the same cycle.
      if (push && !do_push) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end
endmodule

// File: rtl/ps2_ascii_buffer.sv
// PS/2 scan codes to queued ASCII; event at edge k gives ascii_valid after edge k+2 on an empty queue.
// Consumer pops with ascii_ready; a full queue drops new entries and sets overflow.
module ps2_ascii_buffer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int EMIT_BREAK = 0,
  parameter int CTRL_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_code_new,
  input  logic [7:0]                    ps2_code,
  output logic                          ascii_valid,
  output logic [7:0]                    ascii_code,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          caps_lock,
  output logic [2:0]                    mods
);
  state_t     state;
  logic       prev_new, break_flag, e0_flag;
  logic       shift_l, shift_r, ctrl_l, ctrl_r;
  logic       shift_any, ctrl_any, push_en;
  logic [7:0] code_q, push_data;
  xlat_t      tr;

  assign shift_any = shift_l | shift_r;
  assign ctrl_any  = ctrl_l | ctrl_r;
  assign mods      = {ctrl_any, shift_any, e0_flag};

  always_comb tr = ps2_xlat(code_q, shift_any, caps_lock, ctrl_any && (CTRL_EN != 0), e0_flag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= READY;
      prev_new   <= 1'b1;
      break_flag <= 1'b0;
      e0_flag    <= 1'b0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      ctrl_l     <= 1'b0;
      ctrl_r     <= 1'b0;
      caps_lock  <= 1'b0;
      code_q     <= 8'h00;
      push_en    <= 1'b0;
      push_data  <= 8'h00;
    end else begin
      prev_new <= ps2_code_new;
      push_en  <= 1'b0;
      case (state)
        READY: if (ps2_code_new && !prev_new) begin
          code_q <= ps2_code;
          state  <= DECODE;
        end
        DECODE: begin
          if (code_q == CODE_BREAK) begin
            break_flag <= 1'b1;
            state      <= READY;
          end else if (code_q == CODE_EXT) begin
            e0_flag <= 1'b1;
            state   <= READY;
          end else begin
            case (code_q)
              CODE_SHIFT_L: shift_l <= ~break_flag;
              CODE_SHIFT_R: shift_r <= ~break_flag;
              CODE_CTRL: if (e0_flag) ctrl_r <= ~break_flag; else ctrl_l <= ~break_flag;
              CODE_CAPS: if (!break_flag) caps_lock <= ~caps_lock;
              default: ;
            endcase
            push_en    <= tr.valid && (!break_flag || (EMIT_BREAK != 0));
            push_data  <= {break_flag, tr.ascii};
            break_flag <= 1'b0;
            e0_flag    <= 1'b0;
            state      <= PUSH;
          end
        end
        PUSH:    state <= READY;
        default: state <= READY;
      endcase
    end
  end

  ascii_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_en),
    .data     (push_data),
    .pop      (ascii_ready),
    .clr_ovf  (ovf_clr),
    .head     (ascii_code),
    .valid    (ascii_valid),
    .fill     (fill),
    .overflow (overflow)
  );
endmodule
